exception_controller: RTL and testbench

Sequences the coprocessor's exception state on entry to and return from exceptions: overflow and user-input interrupt. It decides which event is taken and latches the cause and EPC. It drives the write strobes for the mBack/sBack/cause/epc registers, redirects the PC to the handler and tracks user/kernel mode. It sits between the control unit / ALU and the coprocessor register bank.

---
 rtl/exc_pkg.sv | 19 +
 rtl/exc_priority_encoder.sv | 26 ++
 rtl/exception_controller.sv | 153 +++++++++++++++
 tb/tb_exception_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the coprocessor exception controller.
package exc_pkg;

   typedef enum logic [2:0] {
      USER,
      TAKE,
      KERNEL,
      RETURN,
      HALT
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_OVF  = 2'd1;
   localparam logic [1:0] CAUSE_IO   = 2'd2;
   localparam logic [1:0] CAUSE_DBL  = 2'd3;

   localparam logic [15:0] DEFAULT_HANDLER_ADDR = 16'h0100;

endpackage

// File: rtl/exc_priority_encoder.sv
// Combinational choice of exception cause and return address for a committing instruction.
module exc_priority_encoder
   import exc_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int PC_STEP = 2
) (
   input  logic             i_overflow,
   input  logic             i_io_request,
   input  logic             i_interrupts_enabled,
   input  logic [WIDTH-1:0] i_pc_current,
   output logic             o_take,
   output logic [1:0]       o_cause,
   output logic [WIDTH-1:0] o_epc
);

   logic w_io;

   assign w_io   = i_io_request & i_interrupts_enabled;
   assign o_take = i_overflow | w_io;

   // Overflow re-executes the faulting instruction; an interrupt resumes after it.
   assign o_cause = i_overflow ? CAUSE_OVF : (w_io ? CAUSE_IO : CAUSE_NONE);
   assign o_epc   = i_overflow ? i_pc_current : i_pc_current + WIDTH'(PC_STEP);

endmodule

// File: rtl/exception_controller.sv
// Exception entry/return sequencer: latches cause/EPC, strobes the coprocessor
// register bank, redirects the PC and tracks user/kernel mode.
module exception_controller
   import exc_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] HANDLER_ADDR = WIDTH'(DEFAULT_HANDLER_ADDR),
   parameter int               PC_STEP      = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             overflow,
   input  logic             io_request,
   input  logic             interrupts_enabled,
   input  logic             instr_commit,
   input  logic             ret_exc,
   input  logic [WIDTH-1:0] pc_current,
   output logic [WIDTH-1:0] epc_in,
   output logic             epc_write,
   output logic [1:0]       cause_in,
   output logic             cause_write,
   output logic             mback_write,
   output logic             sback_write,
   output logic             restore,
   output logic             pc_redirect,
   output logic [WIDTH-1:0] pc_target,
   output logic             io_ack,
   output logic             mode,
   output logic             halted
);

   state_t           r_state, w_next_state;
   logic [1:0]       r_cause, w_next_cause;
   logic [WIDTH-1:0] r_epc, w_next_epc;
   logic [WIDTH-1:0] r_target, w_next_target;
   logic             r_epc_write, w_next_epc_write;
   logic             r_cause_write, w_next_cause_write;
   logic             r_bank_write, w_next_bank_write;
   logic             r_restore, w_next_restore;
   logic             r_redirect, w_next_redirect;
   logic             r_io_ack, w_next_io_ack;
   logic             r_halted, w_next_halted;

   logic             w_take;
   logic [1:0]       w_pick_cause;
   logic [WIDTH-1:0] w_pick_epc;

   exc_priority_encoder #(
      .WIDTH   (WIDTH),
      .PC_STEP (PC_STEP)
   ) u_priority (
      .i_overflow           (overflow),
      .i_io_request         (io_request),
      .i_interrupts_enabled (interrupts_enabled),
      .i_pc_current         (pc_current),
      .o_take               (w_take),
      .o_cause              (w_pick_cause),
      .o_epc                (w_pick_epc)
   );

   // Outputs are computed for the next state and registered, so every strobe
   // appears in the cycle the FSM occupies the corresponding state.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      w_next_state       = r_state;
      w_next_cause       = r_cause;
      w_next_epc         = r_epc;
      w_next_target      = r_target;
      w_next_epc_write   = 1'b0;
      w_next_cause_write = 1'b0;
      w_next_bank_write  = 1'b0;
      w_next_restore     = 1'b0;
      w_next_redirect    = 1'b0;
      w_next_io_ack      = 1'b0;
      w_next_halted      = 1'b0;

      unique case (r_state)
         USER: begin
            if (instr_commit && w_take) begin
               w_next_state       = TAKE;
               w_next_cause       = w_pick_cause;
               w_next_epc         = w_pick_epc;
               w_next_target      = HANDLER_ADDR;
               w_next_epc_write   = 1'b1;
               w_next_cause_write = 1'b1;
               w_next_bank_write  = 1'b1;
               w_next_redirect    = 1'b1;
               w_next_io_ack      = (w_pick_cause == CAUSE_IO);
            end
         end
         TAKE: w_next_state = KERNEL;
         KERNEL: begin
            if (instr_commit && overflow) begin
               w_next_state       = HALT;
               w_next_cause       = CAUSE_DBL;
               w_next_cause_write = 1'b1;
               w_next_halted      = 1'b1;
            end else if (instr_commit && ret_exc) begin
               w_next_state    = RETURN;
               w_next_target   = r_epc;
               w_next_restore  = 1'b1;
               w_next_redirect = 1'b1;
            end
         end
         RETURN: w_next_state = USER;
         HALT: w_next_halted = 1'b1;
         default: w_next_state = USER;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (reset) begin
         r_state       <= USER;
         r_cause       <= CAUSE_NONE;
         r_epc         <= '0;
         r_target      <= '0;
         r_epc_write   <= 1'b0;
         r_cause_write <= 1'b0;
         r_bank_write  <= 1'b0;
         r_restore     <= 1'b0;
         r_redirect    <= 1'b0;
         r_io_ack      <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_cause       <= w_next_cause;
         r_epc         <= w_next_epc;
         r_target      <= w_next_target;
         r_epc_write   <= w_next_epc_write;
         r_cause_write <= w_next_cause_write;
         r_bank_write  <= w_next_bank_write;
         r_restore     <= w_next_restore;
         r_redirect    <= w_next_redirect;
         r_io_ack      <= w_next_io_ack;
         r_halted      <= w_next_halted;
      end
   end

   assign epc_in      = r_epc;
   assign epc_write   = r_epc_write;
   assign cause_in    = r_cause;
   assign cause_write = r_cause_write;
   assign mback_write = r_bank_write;
   assign sback_write = r_bank_write;
   assign restore     = r_restore;
   assign pc_redirect = r_redirect;
   assign pc_target   = r_target;
   assign io_ack      = r_io_ack;
   assign halted      = r_halted;
   assign mode        = (r_state != USER);

endmodule

// File: tb/tb_exception_controller.sv
// Randomized and directed bench for exception_controller against a transaction-level model.
module tb_exception_controller;

   logic        clock = 1'b0;
   logic        reset, overflow, io_request, interrupts_enabled, instr_commit, ret_exc;
   logic [15:0] pc_current;
   logic [15:0] epc_in, pc_target;
   logic [1:0]  cause_in;
   logic        epc_write, cause_write, mback_write, sback_write, restore;
   logic        pc_redirect, io_ack, mode, halted;

   exception_controller dut (
      .clock              (clock),
      .reset              (reset),
      .overflow           (overflow),
      .io_request         (io_request),
      .interrupts_enabled (interrupts_enabled),
      .instr_commit       (instr_commit),
      .ret_exc            (ret_exc),
      .pc_current         (pc_current),
      .epc_in             (epc_in),
      .epc_write          (epc_write),
      .cause_in           (cause_in),
      .cause_write        (cause_write),
      .mback_write        (mback_write),
      .sback_write        (sback_write),
      .restore            (restore),
      .pc_redirect        (pc_redirect),
      .pc_target          (pc_target),
      .io_ack             (io_ack),
      .mode               (mode),
      .halted             (halted)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [15:0] epc;
      logic        epc_w;
      logic [1:0]  cause;
      logic        cause_w;
      logic        mb_w;
      logic        sb_w;
      logic        rest;
      logic        redir;
      logic [15:0] tgt;
      logic        ack;
      logic        md;
      logic        hlt;
   } out_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   out_t exp_out;

   // Model: "in kernel", "dead", and "one-cycle sequence in flight" flags.
   bit          m_kernel, m_dead, m_busy;
   logic [1:0]  m_cause;
   logic [15:0] m_epc, m_tgt;

   function automatic out_t snap();
      out_t s;
      s.epc = epc_in;   s.epc_w = epc_write; s.cause = cause_in; s.cause_w = cause_write;
      s.mb_w = mback_write; s.sb_w = sback_write; s.rest = restore; s.redir = pc_redirect;
      s.tgt = pc_target; s.ack = io_ack; s.md = mode; s.hlt = halted;
      return s;
   endfunction

   task automatic model_step(input logic rst, ovf, io, ie, com, ret, input logic [15:0] pc);
      out_t e;
      e = '0;
      if (rst) begin
         m_kernel = 0; m_dead = 0; m_busy = 0;
         m_cause = 0; m_epc = 0; m_tgt = 0;
         exp_out = '0;
         return;
      end
      if (m_dead) begin
         // only reset leaves a double fault
      end else if (m_busy) begin
         m_busy = 0;
      end else if (!m_kernel) begin
         if (com && (ovf || (io && ie))) begin
            if (ovf) begin
               m_cause = 2'd1; m_epc = pc;
            end else begin
               m_cause = 2'd2; m_epc = 16'((32'(pc) + 2) % 65536);
            end
            m_tgt = 16'h0100;
            e.epc_w = 1; e.cause_w = 1; e.mb_w = 1; e.sb_w = 1; e.redir = 1;
            e.ack = (m_cause == 2'd2);
            m_kernel = 1; m_busy = 1;
         end
      end else begin
         if (com && ovf) begin
            m_dead = 1; m_cause = 2'd3; e.cause_w = 1;
         end else if (com && ret) begin
            m_tgt = m_epc; e.rest = 1; e.redir = 1; e.md = 1;
            m_kernel = 0; m_busy = 1;
         end
      end
      e.epc = m_epc; e.cause = m_cause; e.tgt = m_tgt; e.hlt = m_dead;
      e.md = e.md | m_kernel | m_dead;
      exp_out = e;
   endtask

   // Apply inputs for one clock, advance the model, and sample 1 time unit after the edge.
   task automatic drive(input logic rst, ovf, io, ie, com, ret, input logic [15:0] pc);
      reset = rst; overflow = ovf; io_request = io; interrupts_enabled = ie;
      instr_commit = com; ret_exc = ret; pc_current = pc;
      model_step(rst, ovf, io, ie, com, ret, pc);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 16'h0000);
      drive(1, 1, 1, 1, 1, 1, 16'h1234);
      n_tests++;
      if (snap() !== out_t'(0)) begin
         n_fail++; $display("FAIL reset_state: got %h want %h", snap(), out_t'(0));
      end
   endtask

   task automatic test_overflow();
      drive(0, 1, 0, 0, 1, 0, 16'h0040);
      n_tests++;
      if (epc_in !== 16'h0040 || cause_in !== 2'd1 || {epc_write, cause_write, mback_write, sback_write} !== 4'hF
          || pc_redirect !== 1'b1 || pc_target !== 16'h0100 || io_ack !== 1'b0 || mode !== 1'b1) begin
         n_fail++; $display("FAIL ovf_take: got %h want epc=0040 cause=1 writes tgt=0100 mode=1", snap());
      end
      drive(0, 0, 0, 0, 0, 0, 16'h0042);
      n_tests++;
      if (snap() !== exp_out) begin n_fail++; $display("FAIL ovf_kernel: got %h want %h", snap(), exp_out); end
      drive(0, 0, 0, 0, 1, 1, 16'h0100);
      n_tests++;
      if (restore !== 1'b1 || pc_redirect !== 1'b1 || pc_target !== 16'h0040 || mode !== 1'b1) begin
         n_fail++; $display("FAIL ovf_return: got %h want restore tgt=0040", snap());
      end
      drive(0, 0, 0, 0, 0, 0, 16'h0040);
      n_tests++;
      if (snap() !== exp_out || mode !== 1'b0) begin
         n_fail++; $display("FAIL ovf_user: got %h want %h", snap(), exp_out);
      end
   endtask

   task automatic test_io_wrap();
      drive(0, 0, 1, 1, 1, 0, 16'hFFFE);
      n_tests++;
      if (epc_in !== 16'h0000 || cause_in !== 2'd2 || io_ack !== 1'b1 || epc_write !== 1'b1) begin
         n_fail++; $display("FAIL io_wrap: got %h want epc=0000 cause=2 ack=1", snap());
      end
      drive(0, 0, 0, 0, 0, 0, 16'h0100);
      n_tests++;
      if (io_ack !== 1'b0 || snap() !== exp_out) begin
         n_fail++; $display("FAIL io_ack_pulse: got %h want %h", snap(), exp_out);
      end
      drive(0, 0, 1, 1, 1, 1, 16'h0102);
      n_tests++;
      if (restore !== 1'b1 || pc_target !== 16'h0000) begin
         n_fail++; $display("FAIL io_return: got %h want restore tgt=0000", snap());
      end
      drive(0, 0, 0, 0, 0, 0, 16'h0000);
      n_tests++;
      if (mode !== 1'b0 || snap() !== exp_out) begin
         n_fail++; $display("FAIL io_user: got %h want %h", snap(), exp_out);
      end
   endtask

   task automatic test_both();
      drive(0, 1, 1, 1, 1, 0, 16'h0010);
      n_tests++;
      if (cause_in !== 2'd1 || epc_in !== 16'h0010 || io_ack !== 1'b0) begin
         n_fail++; $display("FAIL both_priority: got %h want cause=1 epc=0010 ack=0", snap());
      end
      drive(0, 0, 1, 1, 0, 0, 16'h0100);
      drive(0, 0, 1, 1, 1, 1, 16'h0102);
      drive(0, 0, 1, 1, 0, 0, 16'h0010);
      n_tests++;
      if (snap() !== exp_out || io_ack !== 1'b0) begin
         n_fail++; $display("FAIL both_return_gap: got %h want %h", snap(), exp_out);
      end
      drive(0, 0, 1, 1, 1, 0, 16'h0012);
      n_tests++;
      if (cause_in !== 2'd2 || epc_in !== 16'h0014 || io_ack !== 1'b1) begin
         n_fail++; $display("FAIL both_pending_io: got %h want cause=2 epc=0014 ack=1", snap());
      end
      drive(0, 0, 0, 0, 0, 0, 16'h0100);
      drive(0, 0, 0, 0, 1, 1, 16'h0102);
      drive(0, 0, 0, 0, 0, 0, 16'h0014);
   endtask

   task automatic test_masked_and_double();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 0, 1, 0, 16'(16'h0200 + 2 * i));
         n_tests++;
         if ({epc_write, cause_write, mback_write, sback_write, pc_redirect, io_ack} !== 6'd0 || mode !== 1'b0) begin
            n_fail++; $display("FAIL masked_io[%0d]: got %h want no strobes mode=0", i, snap());
         end
      end
      drive(0, 1, 0, 0, 1, 0, 16'h0300);
      drive(0, 0, 0, 0, 1, 0, 16'h0100);
      drive(0, 1, 0, 0, 1, 1, 16'h0102);
      n_tests++;
      if (cause_in !== 2'd3 || cause_write !== 1'b1 || halted !== 1'b1 || epc_write !== 1'b0
          || restore !== 1'b0 || epc_in !== 16'h0300) begin
         n_fail++; $display("FAIL double_fault: got %h want cause=3 cause_write halted", snap());
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
         n_tests++;
         if (halted !== 1'b1 || cause_write !== 1'b0 || mode !== 1'b1 || snap() !== exp_out) begin
            n_fail++; $display("FAIL halt_hold[%0d]: got %h want %h", i, snap(), exp_out);
         end
      end
      drive(1, 0, 0, 0, 0, 0, 16'h0000);
      n_tests++;
      if (snap() !== out_t'(0)) begin n_fail++; $display("FAIL halt_reset: got %h want 0", snap()); end
   endtask

   task automatic test_reset_mid();
      drive(0, 1, 0, 0, 1, 0, 16'h0444);
      drive(1, 0, 0, 0, 0, 0, 16'h0100);
      n_tests++;
      if (snap() !== out_t'(0)) begin n_fail++; $display("FAIL reset_in_take: got %h want 0", snap()); end
      drive(0, 0, 0, 0, 1, 1, 16'h0500);
      n_tests++;
      if (snap() !== out_t'(0) || snap() !== exp_out) begin
         n_fail++; $display("FAIL ret_in_user: got %h want %h", snap(), exp_out);
      end
   endtask

   task automatic test_random();
      logic rst, ovf, io, ie, com, ret;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         ovf = ($urandom_range(0, 7) == 0);
         io  = ($urandom_range(0, 3) == 0);
         ie  = 1'($urandom);
         com = ($urandom_range(0, 3) != 0);
         ret = ($urandom_range(0, 2) == 0);
         drive(rst, ovf, io, ie, com, ret, 16'($urandom_range(0, 65535)));
         n_tests++;
         if (snap() !== exp_out) begin
            n_fail++; $display("FAIL random[%0d]: got %h want %h", i, snap(), exp_out);
         end
      end
   endtask

   initial begin
      reset = 1'b1; overflow = 0; io_request = 0; interrupts_enabled = 0;
      instr_commit = 0; ret_exc = 0; pc_current = '0;
      exp_out = '0;
      test_reset();
      test_overflow();
      test_io_wrap();
      test_both();
      test_masked_and_double();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
